mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single ram256x8 memory between two requesters: the CPU datapath (priority port 0) and a debug/preload port (port 1). The debug port loads and dumps memory without hierarchical access.
- Each requester uses the existing MOV/MOC four-phase handshake.
- The arbiter sequences RAM accesses, range-checks addresses, routes MOC and read data back to the granted requester, and enforces a watchdog on RAM latency.

Parameters:
- MEM_BYTES, 256, addressable RAM size in bytes.
- TIMEOUT, 16, max cycles RAM_MOV may stay high without RAM_MOC before abort (>=2).
- CNT_W, 5, watchdog counter width (must hold TIMEOUT).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPU_MOV  in  1  CPU request; held until CPU_MOC seen.
- CPU_RW  in  1  1=read, 0=write.
- CPU_MS  in  3  [1:0] size 00 byte / 01 halfword / 1x word; [2] signed read.
- CPU_ADDR  in  32  byte address.
- CPU_DIN  in  32  write data.
- CPU_MOC  out  1  operation complete to CPU.
- CPU_DOUT  out  32  registered read data.
- DBG_MOV, DBG_RW, DBG_MS, DBG_ADDR, DBG_DIN, DBG_MOC, DBG_DOUT: same as the CPU group, for the debug port.
- RAM_MOV  out  1  request to RAM.
- RAM_RW  out  1  to RAM ReadWrite.
- RAM_MS  out  3  to RAM MS_2_0.
- RAM_ADDR  out  32  to RAM.
- RAM_DIN  out  32  write data to RAM.
- RAM_DOUT  in  32  RAM read data.
- RAM_MOC  in  1  RAM complete.
- GRANT  out  2  one-hot owner: [0]=CPU, [1]=DBG.
- ERR_CLR  in  1  clears sticky error flags.
- TIMEOUT_ERR  out  1  sticky; set on watchdog abort.
- RANGE_ERR  out  1  sticky; set on out-of-range request.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; last_served=DBG, so the CPU wins the first tie.
  - Reset mid-transaction abandons it; RAM_MOV drops at that edge.
- States: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE:
  - If exactly one MOV is high, grant it.
  - If both are high, grant the port that is not last_served (round-robin).
  - GRANT is registered and set at the transition edge.
  - Range check at grant: addr + nbytes > MEM_BYTES (nbytes = 1/2/4 from MS[1:0]) sets RANGE_ERR and goes to RESPOND with DOUT=0 and no RAM access.
  - Otherwise go to ACCESS with RAM_MOV=1 registered, so RAM_MOV rises 1 cycle after MOV is first sampled.
- ACCESS:
  - RAM_RW/MS/ADDR/DIN are combinationally muxed from the granted port; all are 0 when there is no grant.
  - Watchdog counter increments each cycle from 0.
  - On RAM_MOC=1: capture RAM_DOUT into the granted DOUT (reads only; writes leave DOUT unchanged), drop RAM_MOV, go to RESPOND.
  - If the count reaches TIMEOUT-1 with RAM_MOC still 0: set TIMEOUT_ERR, DOUT=0, drop RAM_MOV, go to RESPOND.
  - RAM_MOC wins if it arrives on the same cycle as the timeout.
- RESPOND:
  - Assert the granted port's MOC (registered).
  - Update last_served.
  - Go to RELEASE.
- RELEASE:
  - Hold MOC high until the granted MOV=0 and RAM_MOC=0.
  - Then drop MOC and GRANT at the same edge and return to IDLE.
  - This guarantees at least one idle cycle between grants.
- Requester drops MOV during ACCESS (abort): the RAM transaction still completes or times out; RESPOND/RELEASE then finish normally and RELEASE exits at once.
- Non-granted port: its MOC stays 0 and its requests wait; a request is never dropped.
- ERR_CLR clears both sticky flags. A new error set in the same cycle as ERR_CLR wins and the flag stays set.
- Best case latency, MOV high to MOC high: 3 cycles plus RAM latency.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2, RELEASE=2'd3);
  - MS size encodings (MS_BYTE=2'b00, MS_HALF=2'b01, MS_WORD=2'b10);
  - port index constants (PORT_CPU=0, PORT_DBG=1).
- One sub-module, mem_arb_watchdog:
  - inputs: CLK, RESET, start, stop;
  - output: expired;
  - contains the CNT_W counter.

Test Plan:
- CPU read, word, addr 0x10; RAM model MOC after 2 cycles with 0xE3A01005 -> CPU_MOC at cycle 5, CPU_DOUT=0xE3A01005, GRANT=01, DBG_MOC stays 0.
- CPU_MOV and DBG_MOV both rise at the same edge after reset -> CPU served first; DBG granted only after the CPU's MOV/MOC release; next simultaneous pair goes DBG first.
- DBG byte write addr 0xFF -> accepted. DBG word write addr 0xFD -> RANGE_ERR=1, DBG_MOC high, RAM_MOV never asserted; ERR_CLR pulse -> RANGE_ERR=0.
- RAM model never returns MOC -> RAM_MOV drops after 16 cycles, TIMEOUT_ERR=1, CPU_MOC=1, CPU_DOUT=0.
- RESET asserted on the 2nd ACCESS cycle -> next edge: RAM_MOV=0, GRANT=00, all MOC=0, state IDLE.
- CPU drops MOV during ACCESS -> RAM completes, CPU_MOC pulses 1 cycle, arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the two-port RAM arbiter:
//   - FSM state encoding (raw localparams plus the enum built from them)
//   - memory-size (MS[1:0]) encodings
//   - requester port indices into the one-hot GRANT vector
//   - helpers that turn an MS size code into a byte count and range-check
//     an access against the RAM size
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_ACCESS  = ACCESS,
    ST_RESPOND = RESPOND,
    ST_RELEASE = RELEASE
  } arb_state_e;

  // MS[1:0] size encodings; 2'b11 behaves as a word
  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;

  // Port indices into GRANT
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [2:0] ms_nbytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      MS_BYTE: n = 3'd1;
      MS_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True when every byte of the access lies inside [0, mem_bytes).
  // Evaluated in 33 bits so an address near 2^32 cannot wrap into range.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [1:0]  sz,
                                         input int          mem_bytes);
    logic [32:0] end_excl;
    logic [32:0] limit;
    end_excl = {1'b0, addr} + {30'd0, ms_nbytes(sz)};
    limit    = 33'($unsigned(mem_bytes));
    return (end_excl <= limit);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
//
// Latency watchdog for one RAM access.
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset
//   start    in   pulse: (re)arm the counter at 0
//   stop     in   pulse: disarm (access finished or aborted)
//   expired  out  armed and the count has reached TIMEOUT-1
//
// The count advances once per armed cycle and holds once expired, so the
// owner sees expired stay high until it asserts stop.
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic stop,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign expired = run_q && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (stop) begin
      run_d = 1'b0;
    end else if (run_q && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule : mem_arb_watchdog

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one ram256x8 between the CPU datapath (port 0) and a debug/preload
// port (port 1). Both requesters and the RAM use the MOV/MOC four-phase
// handshake:
//   requester raises MOV with RW/MS/ADDR/DIN stable; the responder raises MOC
//   when done; requester drops MOV; responder drops MOC. A new request may
//   only start once both are low.
//
// Ports
//   CLK, RESET                 clock / synchronous active-high reset
//   CPU_MOV/RW/MS/ADDR/DIN     CPU request group (inputs)
//   CPU_MOC, CPU_DOUT          CPU completion and registered read data
//   DBG_*                      same as CPU_* for the debug port
//   RAM_MOV/RW/MS/ADDR/DIN     request to the RAM (RW..DIN muxed from owner)
//   RAM_DOUT, RAM_MOC          RAM read data and completion
//   GRANT                      one-hot owner, [0]=CPU [1]=DBG, registered
//   ERR_CLR                    clears both sticky error flags
//   TIMEOUT_ERR, RANGE_ERR     sticky error flags
//   ARB_STATE                  current FSM state, for observation
//
// Flow: IDLE -> (grant) ACCESS -> RESPOND -> RELEASE -> IDLE. An
// out-of-range request skips ACCESS and never touches the RAM.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  // CPU port
  input  logic        CPU_MOV,
  input  logic        CPU_RW,
  input  logic [2:0]  CPU_MS,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_DIN,
  output logic        CPU_MOC,
  output logic [31:0] CPU_DOUT,
  // Debug port
  input  logic        DBG_MOV,
  input  logic        DBG_RW,
  input  logic [2:0]  DBG_MS,
  input  logic [31:0] DBG_ADDR,
  input  logic [31:0] DBG_DIN,
  output logic        DBG_MOC,
  output logic [31:0] DBG_DOUT,
  // RAM side
  output logic        RAM_MOV,
  output logic        RAM_RW,
  output logic [2:0]  RAM_MS,
  output logic [31:0] RAM_ADDR,
  output logic [31:0] RAM_DIN,
  input  logic [31:0] RAM_DOUT,
  input  logic        RAM_MOC,
  // Status
  output logic [1:0]  GRANT,
  input  logic        ERR_CLR,
  output logic        TIMEOUT_ERR,
  output logic        RANGE_ERR,
  output logic [1:0]  ARB_STATE
);

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  arb_state_e  state_q;
  logic [1:0]  grant_q;
  logic        ram_mov_q;
  logic        cpu_moc_q;
  logic        dbg_moc_q;
  logic [31:0] cpu_dout_q;
  logic [31:0] dbg_dout_q;
  logic        last_dbg_q;     // 1: the debug port was served last
  logic        timeout_err_q;
  logic        range_err_q;

  // -------------------------------------------------------------------------
  // Arbitration choice in IDLE
  // -------------------------------------------------------------------------
  logic        pick_valid;
  logic        pick_dbg;
  logic [2:0]  pick_ms;
  logic [31:0] pick_addr;
  logic        pick_ok;

  always_comb begin
    pick_valid = CPU_MOV | DBG_MOV;
    // On a tie the port that was not served last wins.
    pick_dbg   = DBG_MOV & (~CPU_MOV | ~last_dbg_q);
    pick_ms    = pick_dbg ? DBG_MS   : CPU_MS;
    pick_addr  = pick_dbg ? DBG_ADDR : CPU_ADDR;
    pick_ok    = addr_in_range(pick_addr, pick_ms[1:0], MEM_BYTES);
  end

  // -------------------------------------------------------------------------
  // Owner mux: RAM request fields follow the granted port, zero when idle
  // -------------------------------------------------------------------------
  logic gnt_mov;
  logic gnt_rw;

  always_comb begin
    gnt_mov  = 1'b0;
    gnt_rw   = 1'b0;
    RAM_RW   = 1'b0;
    RAM_MS   = 3'd0;
    RAM_ADDR = 32'd0;
    RAM_DIN  = 32'd0;
    case (grant_q)
      2'b01: begin
        gnt_mov  = CPU_MOV;
        gnt_rw   = CPU_RW;
        RAM_RW   = CPU_RW;
        RAM_MS   = CPU_MS;
        RAM_ADDR = CPU_ADDR;
        RAM_DIN  = CPU_DIN;
      end
      2'b10: begin
        gnt_mov  = DBG_MOV;
        gnt_rw   = DBG_RW;
        RAM_RW   = DBG_RW;
        RAM_MS   = DBG_MS;
        RAM_ADDR = DBG_ADDR;
        RAM_DIN  = DBG_DIN;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Event decodes shared by the FSM, the watchdog and the error flags
  // -------------------------------------------------------------------------
  logic wd_expired;
  logic in_idle, in_access;
  logic grant_ok, range_set;
  logic ram_done, wd_abort;

  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    in_access = (state_q == ST_ACCESS);
    grant_ok  = in_idle & pick_valid & pick_ok;
    range_set = in_idle & pick_valid & ~pick_ok;
    ram_done  = in_access & RAM_MOC;
    // A completion arriving with the expiry takes precedence.
    wd_abort  = in_access & ~RAM_MOC & wd_expired;
  end

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (grant_ok),
    .stop    (ram_done | wd_abort),
    .expired (wd_expired)
  );

  // -------------------------------------------------------------------------
  // Main FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      ram_mov_q  <= 1'b0;
      cpu_moc_q  <= 1'b0;
      dbg_moc_q  <= 1'b0;
      cpu_dout_q <= 32'd0;
      dbg_dout_q <= 32'd0;
      last_dbg_q <= 1'b1;   // CPU wins the first tie
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_dbg ? 2'b10 : 2'b01;
            if (pick_ok) begin
              ram_mov_q <= 1'b1;
              state_q   <= ST_ACCESS;
            end else begin
              // Rejected: answer with zero data, RAM is never asked.
              if (pick_dbg) dbg_dout_q <= 32'd0;
              else          cpu_dout_q <= 32'd0;
              state_q <= ST_RESPOND;
            end
          end
        end

        ST_ACCESS: begin
          if (RAM_MOC) begin
            ram_mov_q <= 1'b0;
            if (gnt_rw) begin
              if (grant_q[PORT_DBG]) dbg_dout_q <= RAM_DOUT;
              else                   cpu_dout_q <= RAM_DOUT;
            end
            state_q <= ST_RESPOND;
          end else if (wd_expired) begin
            ram_mov_q <= 1'b0;
            if (grant_q[PORT_DBG]) dbg_dout_q <= 32'd0;
            else                   cpu_dout_q <= 32'd0;
            state_q <= ST_RESPOND;
          end
        end

        ST_RESPOND: begin
          cpu_moc_q  <= grant_q[PORT_CPU];
          dbg_moc_q  <= grant_q[PORT_DBG];
          last_dbg_q <= grant_q[PORT_DBG];
          state_q    <= ST_RELEASE;
        end

        ST_RELEASE: begin
          // Wait for both handshakes to return to zero before freeing the
          // port; the IDLE visit that follows separates consecutive grants.
          if (!gnt_mov && !RAM_MOC) begin
            cpu_moc_q <= 1'b0;
            dbg_moc_q <= 1'b0;
            grant_q   <= 2'b00;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags: a new error beats a simultaneous clear
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timeout_err_q <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      timeout_err_q <= wd_abort  | (timeout_err_q & ~ERR_CLR);
      range_err_q   <= range_set | (range_err_q   & ~ERR_CLR);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign CPU_MOC     = cpu_moc_q;
  assign CPU_DOUT    = cpu_dout_q;
  assign DBG_MOC     = dbg_moc_q;
  assign DBG_DOUT    = dbg_dout_q;
  assign RAM_MOV     = ram_mov_q;
  assign GRANT       = grant_q;
  assign TIMEOUT_ERR = timeout_err_q;
  assign RANGE_ERR   = range_err_q;
  assign ARB_STATE   = state_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A transaction-level model predicts,
// per request, which port is answered, the data returned, the MOV-to-MOC
// latency and the RAM access (if any) the arbiter must issue. A single
// negedge monitor checks those predictions plus per-cycle structural rules;
// directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        CPU_MOV = 0, CPU_RW = 0, DBG_MOV = 0, DBG_RW = 0;
  logic [2:0]  CPU_MS = 0, DBG_MS = 0;
  logic [31:0] CPU_ADDR = 0, CPU_DIN = 0, DBG_ADDR = 0, DBG_DIN = 0;
  logic        CPU_MOC, DBG_MOC;
  logic [31:0] CPU_DOUT, DBG_DOUT;
  logic        RAM_MOV, RAM_RW;
  logic [2:0]  RAM_MS;
  logic [31:0] RAM_ADDR, RAM_DIN, RAM_DOUT;
  logic        RAM_MOC;
  logic [1:0]  GRANT, ARB_STATE;
  logic        ERR_CLR = 0;
  logic        TIMEOUT_ERR, RANGE_ERR;

  mem_port_arbiter #(.MEM_BYTES(256), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_MOV(CPU_MOV), .CPU_RW(CPU_RW), .CPU_MS(CPU_MS), .CPU_ADDR(CPU_ADDR),
    .CPU_DIN(CPU_DIN), .CPU_MOC(CPU_MOC), .CPU_DOUT(CPU_DOUT),
    .DBG_MOV(DBG_MOV), .DBG_RW(DBG_RW), .DBG_MS(DBG_MS), .DBG_ADDR(DBG_ADDR),
    .DBG_DIN(DBG_DIN), .DBG_MOC(DBG_MOC), .DBG_DOUT(DBG_DOUT),
    .RAM_MOV(RAM_MOV), .RAM_RW(RAM_RW), .RAM_MS(RAM_MS), .RAM_ADDR(RAM_ADDR),
    .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT), .RAM_MOC(RAM_MOC),
    .GRANT(GRANT), .ERR_CLR(ERR_CLR), .TIMEOUT_ERR(TIMEOUT_ERR),
    .RANGE_ERR(RANGE_ERR), .ARB_STATE(ARB_STATE)
  );

  // ---------------- RAM responder ----------------
  // ram_lat > 0: MOC raised ram_lat cycles after RAM_MOV is seen; 0: never.
  int   ram_lat = 2;
  int   ram_cnt = 0;
  logic ram_moc = 0;
  assign RAM_MOC = ram_moc;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A01005;
    return {a[15:0], ~a[15:0]};
  endfunction
  assign RAM_DOUT = ram_word(RAM_ADDR);

  always @(posedge CLK) begin
    if (!RAM_MOV) begin
      ram_moc <= 1'b0;
      ram_cnt <= 0;
    end else if (!ram_moc && ram_lat > 0) begin
      if (ram_cnt == ram_lat - 1) ram_moc <= 1'b1;
      else                        ram_cnt <= ram_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected answers: {port, dout[31:0], latency[7:0]}; latency 0 = not timed.
  logic [40:0] exp_q[$];
  // Expected RAM accesses: {rw, ms[2:0], addr[31:0], din[31:0]}.
  logic [67:0] ram_exp_q[$];

  // ---------------- transaction model ----------------
  logic [31:0] m_dout [2];
  int          m_last = 1;   // port served last; reset value: debug

  function automatic int model_winner(input bit cpu, input bit dbg);
    if (cpu && dbg) return (m_last == 1) ? 0 : 1;
    return dbg ? 1 : 0;
  endfunction

  function automatic void model_txn(input int port, input logic rw, input logic [2:0] ms,
                                    input logic [31:0] addr, input logic [31:0] din,
                                    input bit timed);
    int nbytes;
    int lat;
    logic [7:0] lat8;
    nbytes = ms[1] ? 4 : (ms[0] ? 2 : 1);
    if (longint'(addr) + nbytes > 256) begin
      m_dout[port] = 32'd0;
      lat = 2;
    end else begin
      ram_exp_q.push_back({rw, ms, addr, din});
      if (ram_lat == 0) begin
        m_dout[port] = 32'd0;
        lat = TIMEOUT + 2;
      end else begin
        if (rw) m_dout[port] = ram_word(addr);
        lat = ram_lat + 3;
      end
    end
    if (!timed) lat = 0;
    lat8 = lat[7:0];
    m_last = port;
    exp_q.push_back({(port == 1), m_dout[port], lat8});
  endfunction

  function automatic void model_reset();
    m_last = 1;
    m_dout[0] = 32'd0;
    m_dout[1] = 32'd0;
  endfunction

  // ---------------- compare process ----------------
  int   start_cyc [2];
  int   last_lat [2];
  logic [1:0] moc_grant;
  int   order_q[$];
  int   dbg_rises = 0;
  int   ram_rises = 0;
  int   ram_run = 0;
  int   ram_last_len = 0;
  logic prev_cpu = 0, prev_dbg = 0, prev_ram = 0;

  task automatic moc_event(input int port, input logic [31:0] dout);
    logic [40:0] e;
    order_q.push_back(port);
    moc_grant = GRANT;
    last_lat[port] = cyc - start_cyc[port];
    if (exp_q.size() == 0) begin
      check("moc_unexpected", port, 99);
    end else begin
      e = exp_q.pop_front();
      check("moc_port", port, e[40]);
      check("moc_dout", dout, e[39:8]);
      if (e[7:0] != 8'd0) check("moc_latency", last_lat[port], e[7:0]);
    end
  endtask

  always @(negedge CLK) begin
    logic [67:0] mux_exp;
    check("grant_legal", (GRANT == 2'b11), 0);
    case (GRANT)
      2'b01:   mux_exp = {CPU_RW, CPU_MS, CPU_ADDR, CPU_DIN};
      2'b10:   mux_exp = {DBG_RW, DBG_MS, DBG_ADDR, DBG_DIN};
      default: mux_exp = '0;
    endcase
    check("ram_mux", {RAM_RW, RAM_MS, RAM_ADDR, RAM_DIN}, mux_exp);
    check("owner", {CPU_MOC & ~GRANT[0], DBG_MOC & ~GRANT[1], RAM_MOV & (GRANT == 2'b00)}, 0);
    if (RAM_MOV && !prev_ram) begin
      ram_rises++;
      if (ram_exp_q.size() == 0) check("ram_unexpected", RAM_ADDR, 32'hFFFF_FFFF);
      else                       check("ram_access", {RAM_RW, RAM_MS, RAM_ADDR, RAM_DIN}, ram_exp_q.pop_front());
    end
    if (RAM_MOV) ram_run++;
    else if (prev_ram) begin ram_last_len = ram_run; ram_run = 0; end
    if (CPU_MOC && !prev_cpu) moc_event(0, CPU_DOUT);
    if (DBG_MOC && !prev_dbg) begin dbg_rises++; moc_event(1, DBG_DOUT); end
    prev_ram = RAM_MOV;
    prev_cpu = CPU_MOC;
    prev_dbg = DBG_MOC;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    CPU_MOV = 0;
    DBG_MOV = 0;
    step();
    step();
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic drive_req(input int port, input logic rw, input logic [2:0] ms,
                           input logic [31:0] addr, input logic [31:0] din);
    start_cyc[port] = cyc;
    if (port == 0) begin
      CPU_RW = rw; CPU_MS = ms; CPU_ADDR = addr; CPU_DIN = din; CPU_MOV = 1'b1;
    end else begin
      DBG_RW = rw; DBG_MS = ms; DBG_ADDR = addr; DBG_DIN = din; DBG_MOV = 1'b1;
    end
  endtask

  task automatic wait_moc_release(input int port, input int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge CLK);
      if ((port == 0) ? CPU_MOC : DBG_MOC) got = 1;
    end
    if (!got) check($sformatf("moc_wait_p%0d", port), 0, 1);
    if (port == 0) CPU_MOV = 1'b0;
    else           DBG_MOV = 1'b0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK);
      if (!((port == 0) ? CPU_MOC : DBG_MOC)) got = 1;
    end
    if (!got) check($sformatf("moc_release_p%0d", port), 0, 1);
  endtask

  task automatic single(input int port, input logic rw, input logic [2:0] ms,
                        input logic [31:0] addr, input logic [31:0] din);
    step();
    model_txn(port, rw, ms, addr, din, 1);
    drive_req(port, rw, ms, addr, din);
    wait_moc_release(port, 60);
  endtask

  task automatic err_clr_pulse();
    step();
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
  endtask

  task automatic pair(input logic [31:0] cpu_addr, input logic [31:0] dbg_addr);
    int w;
    step();
    order_q.delete();
    w = model_winner(1, 1);
    if (w == 0) begin
      model_txn(0, 1, 3'b010, cpu_addr, 0, 1);
      model_txn(1, 1, 3'b010, dbg_addr, 0, 0);
    end else begin
      model_txn(1, 1, 3'b010, dbg_addr, 0, 1);
      model_txn(0, 1, 3'b010, cpu_addr, 0, 0);
    end
    drive_req(0, 1, 3'b010, cpu_addr, 0);
    drive_req(1, 1, 3'b010, dbg_addr, 0);
    fork
      wait_moc_release(0, 100);
      wait_moc_release(1, 100);
    join
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int rises0;
    model_reset();
    do_reset();
    @(negedge CLK);
    check("rst_outputs", {GRANT, RAM_MOV, CPU_MOC, DBG_MOC, TIMEOUT_ERR, RANGE_ERR, ARB_STATE}, 0);
    check("rst_dout", {CPU_DOUT, DBG_DOUT}, 0);

    // CPU word read at 0x10, RAM latency 2
    ram_lat = 2;
    single(0, 1, 3'b010, 32'h10, 0);
    check("t1_dout", CPU_DOUT, 32'hE3A01005);
    check("t1_latency", last_lat[0], 5);
    check("t1_grant", moc_grant, 2'b01);
    check("t1_dbg_moc", dbg_rises, 0);

    // Tie after reset: CPU first; then after a CPU-only access, DBG first
    do_reset();
    pair(32'h20, 32'h24);
    check("rr1_count", order_q.size(), 2);
    check("rr1_order", {order_q[0][1:0], order_q[1][1:0]}, 4'b00_01);
    single(0, 1, 3'b000, 32'h30, 0);
    pair(32'h40, 32'h44);
    check("rr2_count", order_q.size(), 2);
    check("rr2_order", {order_q[0][1:0], order_q[1][1:0]}, 4'b01_00);

    // Debug port range boundaries
    single(1, 0, 3'b000, 32'hFF, 32'h5A);
    check("byte_ff_ok", RANGE_ERR, 0);
    single(1, 1, 3'b001, 32'hFE, 0);
    check("half_fe_ok", {RANGE_ERR, DBG_DOUT}, {1'b0, 32'h00FEFF01});
    rises0 = ram_rises;
    single(1, 0, 3'b010, 32'hFD, 32'h1234);
    check("word_fd_err", {RANGE_ERR, DBG_DOUT}, {1'b1, 32'h0});
    check("word_fd_noram", ram_rises - rises0, 0);
    check("word_fd_latency", last_lat[1], 2);
    err_clr_pulse();
    check("range_clr", RANGE_ERR, 0);
    // Error set on the same edge as ERR_CLR stays set
    step();
    model_txn(1, 1, 3'b110, 32'h100, 0, 1);
    drive_req(1, 1, 3'b110, 32'h100, 0);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    wait_moc_release(1, 20);
    check("set_beats_clr", RANGE_ERR, 1);
    err_clr_pulse();
    check("range_clr2", RANGE_ERR, 0);

    // Watchdog: RAM never answers
    ram_lat = 0;
    single(0, 1, 3'b010, 32'h20, 0);
    check("to_err", {TIMEOUT_ERR, CPU_DOUT}, {1'b1, 32'h0});
    check("to_ram_len", ram_last_len, TIMEOUT);
    check("to_latency", last_lat[0], 18);
    err_clr_pulse();
    check("to_clr", TIMEOUT_ERR, 0);

    // Reset on the second ACCESS cycle
    step();
    ram_exp_q.push_back({1'b1, 3'b010, 32'h40, 32'h0});
    drive_req(0, 1, 3'b010, 32'h40, 0);
    step();
    step();
    RESET = 1'b1;
    CPU_MOV = 1'b0;
    step();
    check("mid_rst", {RAM_MOV, GRANT, CPU_MOC, DBG_MOC, ARB_STATE}, 0);
    RESET = 1'b0;
    model_reset();
    ram_lat = 2;

    // CPU abandons its request during ACCESS
    step();
    model_txn(0, 1, 3'b010, 32'h80, 0, 1);
    drive_req(0, 1, 3'b010, 32'h80, 0);
    step();
    step();
    CPU_MOV = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (CPU_MOC) n++;
    end
    check("abort_pulse", n, 1);
    check("abort_idle", {ARB_STATE, GRANT}, 0);
    check("abort_dout", CPU_DOUT, 32'h0080FF7F);

    step();
    check("exp_q_empty", exp_q.size(), 0);
    check("ram_q_empty", ram_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_port_arbiter
